// File: rtl/match_collector_if.sv
// Match-pair stream, replay read port and frame status between the matcher,
// match_collector and the downstream pose-estimation stage.
interface match_collector_if #(
  parameter int unsigned CNT_W = 10
);
  logic             i_valid;
  logic [9:0]       i_src_coor_x;
  logic [9:0]       i_src_coor_y;
  logic [9:0]       i_dst_coor_x;
  logic [9:0]       i_dst_coor_y;
  logic             i_end;
  logic             i_rd_ready;
  logic             o_rd_valid;
  logic [9:0]       o_src_coor_x;
  logic [9:0]       o_src_coor_y;
  logic [9:0]       o_dst_coor_x;
  logic [9:0]       o_dst_coor_y;
  logic             o_rd_last;
  logic             o_frame_done;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_busy;

  modport master (
    output i_valid, i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y,
           i_end, i_rd_ready,
    input  o_rd_valid, o_src_coor_x, o_src_coor_y, o_dst_coor_x, o_dst_coor_y,
           o_rd_last, o_frame_done, o_count, o_overflow, o_busy
  );

  modport slave (
    input  i_valid, i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y,
           i_end, i_rd_ready,
    output o_rd_valid, o_src_coor_x, o_src_coor_y, o_dst_coor_x, o_dst_coor_y,
           o_rd_last, o_frame_done, o_count, o_overflow, o_busy
  );
endinterface

// File: rtl/match_collector.sv
// Collects one frame of match pairs into RAM, then replays them in arrival
// order over a valid/ready port once the matcher signals frame end.
module match_collector #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  match_collector_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    COLLECT,
    READ
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_idx;
  logic [CNT_W-1:0] count_q;
  logic             rd_valid_q;
  logic             frame_done_q;
  logic             overflow_q;
  logic             read_drop_q;
  logic [39:0]      mem [DEPTH];
  logic [39:0]      rd_data;

  logic             can_write;
  logic             drop;
  logic [CNT_W-1:0] wr_next_cnt;
  logic             xfer;
  logic             at_last;
  logic             last_xfer;
  logic [CNT_W-1:0] rd_sel;
  logic [AW-1:0]    rd_addr;

  always_comb begin
    can_write   = (state_q == COLLECT) && bus.i_valid && (wr_ptr < CNT_W'(DEPTH));
    drop        = bus.i_valid && !can_write;
    wr_next_cnt = wr_ptr + CNT_W'(can_write);
    xfer        = (state_q == READ) && rd_valid_q && bus.i_rd_ready;
    at_last     = (rd_idx == wr_ptr - CNT_W'(1));
    last_xfer   = xfer && at_last;
    // RAM output is the output register: re-read the presented entry while
    // stalled, fetch the next one on a transfer, giving 1 pair/cycle.
    rd_sel      = xfer ? rd_idx + CNT_W'(1) : rd_idx;
    rd_addr     = rd_sel[AW-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (bus.i_end && (wr_next_cnt != '0)) state_d = READ;
      READ:    if (last_xfer) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (can_write && !i_rst)
      mem[wr_ptr[AW-1:0]] <= {bus.i_src_coor_x, bus.i_src_coor_y,
                              bus.i_dst_coor_x, bus.i_dst_coor_y};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                rd_data <= '0;
    else if (state_q == READ) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_idx       <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      read_drop_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (can_write) begin
            wr_ptr  <= wr_ptr + CNT_W'(1);
            count_q <= wr_ptr + CNT_W'(1);
          end
          if (drop) overflow_q <= 1'b1;
          if (bus.i_end) begin
            frame_done_q <= 1'b1;
            count_q      <= wr_next_cnt;
            rd_idx       <= '0;
            rd_valid_q   <= 1'b0;
            if (wr_next_cnt == '0) overflow_q <= 1'b0;
          end
        end
        READ: begin
          // Losses while replaying are carried into the next frame's report.
          if (drop) begin
            overflow_q  <= 1'b1;
            read_drop_q <= 1'b1;
          end
          if (!rd_valid_q) rd_valid_q <= 1'b1;
          if (xfer) rd_idx <= rd_idx + CNT_W'(1);
          if (last_xfer) begin
            rd_valid_q  <= 1'b0;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            overflow_q  <= read_drop_q | drop;
            read_drop_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rd_valid   = rd_valid_q;
  assign bus.o_src_coor_x = rd_data[39:30];
  assign bus.o_src_coor_y = rd_data[29:20];
  assign bus.o_dst_coor_x = rd_data[19:10];
  assign bus.o_dst_coor_y = rd_data[9:0];
  assign bus.o_rd_last    = rd_valid_q && at_last;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_count      = count_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_busy       = (state_q == READ);

endmodule

// File: doc/match_collector.md
Name: match_collector

Overview:
- Sink end of the matcher output stream: captures `(valid, src_x, src_y, dst_x, dst_y, end)` match pairs for one frame into on-chip storage.
- On frame end, replays the pairs in arrival order over a valid/ready read port to the downstream pose-estimation stage.
- Decouples the bursty matcher output from the slower consumer, and reports per-frame match count and overflow.

Parameters:
- DEPTH, 512, maximum match pairs stored per frame (power of two).
- CNT_W, 10, width of count/pointers; must satisfy `2^CNT_W > DEPTH`.

Ports:
- i_clk  in  1  clock; one clock, all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  match pair present on i_src/i_dst this cycle.
- i_src_coor_x  in  10  source keypoint X.
- i_src_coor_y  in  10  source keypoint Y.
- i_dst_coor_x  in  10  destination keypoint X.
- i_dst_coor_y  in  10  destination keypoint Y.
- i_end  in  1  one-cycle pulse: matcher finished the frame.
- i_rd_ready  in  1  downstream accepts a pair this cycle.
- o_rd_valid  out  1  o_src/o_dst hold a valid stored pair.
- o_src_coor_x  out  10  replayed source X.
- o_src_coor_y  out  10  replayed source Y.
- o_dst_coor_x  out  10  replayed destination X.
- o_dst_coor_y  out  10  replayed destination Y.
- o_rd_last  out  1  high with o_rd_valid on the final pair of the frame.
- o_frame_done  out  1  one-cycle pulse when a frame is closed by i_end.
- o_count  out  CNT_W  pairs stored for the current/last closed frame.
- o_overflow  out  1  sticky: at least one pair of this frame was dropped.
- o_busy  out  1  high while in READ (input stream not accepted).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. i_rst has priority over all other inputs.
- Reset state:
  - State COLLECT; write and read pointers 0.
  - o_rd_valid, o_rd_last, o_frame_done, o_overflow, o_busy = 0; o_count = 0.
  - Coordinate outputs = 0.
- Storage: DEPTH x 40-bit RAM (synchronous read permitted); entry = `{src_x, src_y, dst_x, dst_y}`.
- State COLLECT:
  - i_valid with o_count < DEPTH: write at wr_ptr; wr_ptr and o_count increment on the next edge.
  - i_valid with o_count == DEPTH: pair dropped, o_overflow set to 1.
  - i_valid and i_end in the same cycle: the pair is stored (capacity permitting) before the frame closes.
  - i_end with resulting count > 0: o_frame_done pulses next cycle; state goes to READ; o_busy = 1.
  - i_end with resulting count == 0: o_frame_done pulses; stays in COLLECT; o_overflow cleared; o_rd_valid never asserts.
- State READ:
  - o_rd_valid rises no later than 2 cycles after entering READ.
  - A transfer occurs on every cycle with o_rd_valid && i_rd_ready.
  - Sustained throughput is 1 pair/cycle while i_rd_ready is held high (read-ahead/skid register required with a sync-read RAM).
  - While i_rd_ready is low, data and o_rd_valid hold stable.
  - Pairs are replayed in write order, index 0 .. o_count-1; o_rd_last = 1 only on index o_count-1.
  - On the transfer of the last pair: next cycle state = COLLECT; o_rd_valid = 0, o_busy = 0, pointers = 0, o_overflow = 0. o_count holds until the first write of the new frame, then restarts from 1.
  - i_valid in READ: pair dropped and o_overflow set; it stays set through the next frame until that frame's end, so the loss is reported.
  - i_end in READ: ignored.
- Arithmetic: pointers and count saturate; never wrap. A DEPTH+1th write does not overwrite index 0.
- Reset mid-READ: remaining pairs discarded; outputs return to reset values on the next edge.

Test Plan:
- Basic frame:
  - Stimulus: 3 pairs `(1,2,3,4)`, `(5,6,7,8)`, `(9,10,11,12)`, then i_end, with i_rd_ready=1.
  - Response: o_frame_done pulse and o_count=3; 3 consecutive transfers in order; o_rd_last only on `(9,10,11,12)`; o_busy drops the cycle after.
- Backpressure:
  - Stimulus: same frame, i_rd_ready toggling 1,0,0,1,…
  - Response: output data stable during ready=0; exactly 3 transfers, same order, no duplicates.
- Overflow (DEPTH=4):
  - Stimulus: 6 pairs then i_end.
  - Response: o_count=4, o_overflow=1; replay yields only the first 4 pairs; o_overflow=0 after the last transfer.
- Empty and coincident end:
  - Stimulus: i_end alone.
  - Response: o_frame_done pulse, o_count=0, no o_rd_valid.
  - Stimulus: i_valid and i_end on the same cycle.
  - Response: that pair is stored; o_count=1.
- Input during READ:
  - Stimulus: i_valid pulses while o_busy=1.
  - Response: pairs dropped, o_overflow=1; the replayed set is unchanged.
- Reset mid-READ:
  - Stimulus: assert i_rst after 1 of 3 transfers.
  - Response: next cycle all outputs zero, state COLLECT; a fresh 2-pair frame replays correctly.
